// File: rtl/bcp_implication_queue.sv
// -----------------------------------------------------------------------------
// bcp_implication_queue
//   Consumer end of the BCP unit-clause check. Takes the unit literal of a
//   4-literal clause and turns it into an implied variable assignment. The
//   assignment is recorded in a pending-implication table. New implications
//   are queued in a FIFO for the assignment writer. Repeats of a recorded
//   implication are dropped, and an implication that contradicts a recorded
//   one raises a sticky conflict.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   CLEAR             backtrack: wipe table, FIFO and conflict (one cycle)
//   UNIT_VALID/READY  unit-clause result handshake
//   UNIT_CLAUSE       one-hot (highest bit wins) unit-literal slot flags
//   CLAUSE_VARS       slot k variable index at [k*VAR_W +: VAR_W]
//   CLAUSE_POL        slot polarity, 1 = positive literal
//   IMPL_VALID/READY  implication FIFO head handshake
//   IMPL_VAR/VAL      head entry (0 when FIFO empty)
//   CONFLICT          sticky conflict flag
//   CONFLICT_VAR      variable that caused the conflict
//   COUNT             FIFO occupancy
//
// Optional build macro BCP_IMPL_STATS_EN adds saturating statistics outputs
// IMPL_CNT, DUP_CNT (16 bit) and CONF_CNT (8 bit), cleared by RST only.
// -----------------------------------------------------------------------------
module bcp_implication_queue #(
  parameter int unsigned NUM_VARS = 16,
  parameter int unsigned VAR_W    = 4,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CLEAR,
  input  logic                         UNIT_VALID,
  output logic                         UNIT_READY,
  input  logic [3:0]                   UNIT_CLAUSE,
  input  logic [4*VAR_W-1:0]           CLAUSE_VARS,
  input  logic [3:0]                   CLAUSE_POL,
  output logic                         IMPL_VALID,
  input  logic                         IMPL_READY,
  output logic [VAR_W-1:0]             IMPL_VAR,
  output logic                         IMPL_VAL,
  output logic                         CONFLICT,
  output logic [VAR_W-1:0]             CONFLICT_VAR,
`ifdef BCP_IMPL_STATS_EN
  output logic [15:0]                  IMPL_CNT,
  output logic [15:0]                  DUP_CNT,
  output logic [7:0]                   CONF_CNT,
`endif
  output logic [$clog2(DEPTH):0]       COUNT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = VAR_W + 1;

  typedef enum logic {S_RUN = 1'b0, S_CONFLICT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [NUM_VARS-1:0]   r_assigned;
  logic [NUM_VARS-1:0]   r_value;
  logic [ENT_W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [VAR_W-1:0]      r_conflict_var;

  logic [VAR_W-1:0]      w_var;
  logic                  w_val;
  logic                  w_any;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_lookup;
  logic                  w_present;
  logic                  w_push;
  logic                  w_dup;
  logic                  w_conf;
  logic                  w_pop;
  logic [ENT_W-1:0]      w_head;

  // Implied literal: ascending scan so the highest set flag wins.
  always_comb begin
    w_var = '0;
    w_val = 1'b0;
    w_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (UNIT_CLAUSE[k]) begin
        w_var = CLAUSE_VARS[k*VAR_W +: VAR_W];
        w_val = CLAUSE_POL[k];
        w_any = 1'b1;
      end
    end
  end

  // Table lookup and event decode; CLEAR discards any accept or pop.
  always_comb begin
    w_in_range = (32'(w_var) < NUM_VARS);
    w_accept   = UNIT_VALID & UNIT_READY & ~CLEAR;
    w_lookup   = w_accept & w_any & w_in_range;
    w_present  = w_in_range ? r_assigned[w_var] : 1'b0;
    w_push     = w_lookup & ~w_present;
    w_dup      = w_lookup &  w_present & (r_value[w_var] == w_val);
    w_conf     = w_lookup &  w_present & (r_value[w_var] != w_val);
    // A conflict flushes the FIFO, so a pop in that cycle is ignored.
    w_pop      = IMPL_VALID & IMPL_READY & ~CLEAR & ~w_conf;
    w_head     = r_mem[r_rptr];
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: CONFLICT is left only through CLEAR (or RST).
  always_comb begin
    w_state_nxt = r_state;
    if (CLEAR) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:      if (w_conf) w_state_nxt = S_CONFLICT;
        S_CONFLICT: w_state_nxt = S_CONFLICT;
        default:    w_state_nxt = S_RUN;
      endcase
    end
  end

  // FSM outputs; UNIT_READY is held low while RST is asserted.
  always_comb begin
    UNIT_READY   = 1'b0;
    IMPL_VALID   = 1'b0;
    CONFLICT     = 1'b0;
    IMPL_VAR     = '0;
    IMPL_VAL     = 1'b0;
    COUNT        = r_count;
    CONFLICT_VAR = r_conflict_var;
    case (r_state)
      S_RUN: begin
        UNIT_READY = ~RST & (r_count != CNT_W'(DEPTH));
        IMPL_VALID = (r_count != '0);
      end
      S_CONFLICT: CONFLICT = 1'b1;
      default: ;
    endcase
    if (IMPL_VALID) begin
      IMPL_VAR = w_head[ENT_W-1:1];
      IMPL_VAL = w_head[0];
    end
  end

  // Table, FIFO pointers, occupancy and conflict variable.
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      r_assigned     <= '0;
      r_value        <= '0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_conflict_var <= '0;
    end else if (w_conf) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_conflict_var <= w_var;
    end else begin
      if (w_push) begin
        r_mem[r_wptr]     <= {w_var, w_val};
        r_assigned[w_var] <= 1'b1;
        r_value[w_var]    <= w_val;
        r_wptr            <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BCP_IMPL_STATS_EN
  logic [15:0] r_impl_cnt;
  logic [15:0] r_dup_cnt;
  logic [7:0]  r_conf_cnt;

  // Saturating statistics; survive CLEAR, cleared by RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_impl_cnt <= '0;
      r_dup_cnt  <= '0;
      r_conf_cnt <= '0;
    end else begin
      if (w_push && (r_impl_cnt != 16'hFFFF)) r_impl_cnt <= r_impl_cnt + 16'd1;
      if (w_dup  && (r_dup_cnt  != 16'hFFFF)) r_dup_cnt  <= r_dup_cnt  + 16'd1;
      if (w_conf && (r_conf_cnt != 8'hFF))    r_conf_cnt <= r_conf_cnt + 8'd1;
    end
  end

  assign IMPL_CNT = r_impl_cnt;
  assign DUP_CNT  = r_dup_cnt;
  assign CONF_CNT = r_conf_cnt;
`endif

`ifndef SYNTHESIS
  // Out-of-range variable indices are dropped as no-ops; flag them in sim.
  always_ff @(posedge CLK) begin
    if (!RST && w_accept && w_any) begin
      assert (w_in_range)
        else $error("bcp_implication_queue: variable index %0d out of range", w_var);
    end
  end
`endif

endmodule

// File: tb/tb_bcp_implication_queue.sv
// -----------------------------------------------------------------------------
// tb_bcp_implication_queue
//   Directed bench for bcp_implication_queue with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_bcp_implication_queue;

  localparam int unsigned VAR_W = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CLEAR;
  logic        UNIT_VALID;
  logic        UNIT_READY;
  logic [3:0]  UNIT_CLAUSE;
  logic [15:0] CLAUSE_VARS;
  logic [3:0]  CLAUSE_POL;
  logic        IMPL_VALID;
  logic        IMPL_READY;
  logic [3:0]  IMPL_VAR;
  logic        IMPL_VAL;
  logic        CONFLICT;
  logic [3:0]  CONFLICT_VAR;
  logic [3:0]  COUNT;
`ifdef BCP_IMPL_STATS_EN
  logic [15:0] IMPL_CNT;
  logic [15:0] DUP_CNT;
  logic [7:0]  CONF_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcp_implication_queue #(.NUM_VARS(16), .VAR_W(VAR_W), .DEPTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLEAR        (CLEAR),
    .UNIT_VALID   (UNIT_VALID),
    .UNIT_READY   (UNIT_READY),
    .UNIT_CLAUSE  (UNIT_CLAUSE),
    .CLAUSE_VARS  (CLAUSE_VARS),
    .CLAUSE_POL   (CLAUSE_POL),
    .IMPL_VALID   (IMPL_VALID),
    .IMPL_READY   (IMPL_READY),
    .IMPL_VAR     (IMPL_VAR),
    .IMPL_VAL     (IMPL_VAL),
    .CONFLICT     (CONFLICT),
    .CONFLICT_VAR (CONFLICT_VAR),
`ifdef BCP_IMPL_STATS_EN
    .IMPL_CNT     (IMPL_CNT),
    .DUP_CNT      (DUP_CNT),
    .CONF_CNT     (CONF_CNT),
`endif
    .COUNT        (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_raw(input logic [3:0] clause, input logic [15:0] vars, input logic [3:0] pol);
    UNIT_VALID  = 1'b1;
    UNIT_CLAUSE = clause;
    CLAUSE_VARS = vars;
    CLAUSE_POL  = pol;
    tick();
    UNIT_VALID  = 1'b0;
    UNIT_CLAUSE = 4'b0000;
  endtask

  task automatic push1(input logic [3:0] v, input logic b);
    push_raw(4'b0001, {12'h000, v}, {3'b000, b});
  endtask

  task automatic pop1();
    IMPL_READY = 1'b1;
    tick();
    IMPL_READY = 1'b0;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    RST = 1'b1; CLEAR = 1'b0; UNIT_VALID = 1'b0; UNIT_CLAUSE = '0;
    CLAUSE_VARS = '0; CLAUSE_POL = '0; IMPL_READY = 1'b0;
    tick(); tick();
    check("rst_ready",    UNIT_READY, 0);
    check("rst_valid",    IMPL_VALID, 0);
    check("rst_count",    COUNT, 0);
    check("rst_conflict", CONFLICT, 0);
    check("rst_cvar",     CONFLICT_VAR, 0);
    RST = 1'b0;
    tick();
    check("post_rst_ready", UNIT_READY, 1);
    check("post_rst_var",   IMPL_VAR, 0);

    // Single push: slot 2 carries var 5, negated
    push_raw(4'b0100, 16'h0500, 4'b1011);
    check("single_valid", IMPL_VALID, 1);
    check("single_var",   IMPL_VAR, 5);
    check("single_val",   IMPL_VAL, 0);
    check("single_count", COUNT, 1);
    pop1();
    check("single_pop_count", COUNT, 0);
    check("single_pop_valid", IMPL_VALID, 0);
    check("empty_var_zero",   IMPL_VAR, 0);

    // Zero clause flags is a no-op
    push_raw(4'b0000, 16'h0003, 4'b0001);
    check("noop_count", COUNT, 0);

    // Duplicate
    push1(4'd3, 1'b1);
    push1(4'd3, 1'b1);
    check("dup_count", COUNT, 1);
    check("dup_var",   IMPL_VAR, 3);
    check("dup_val",   IMPL_VAL, 1);
`ifdef BCP_IMPL_STATS_EN
    check("dup_cnt",  DUP_CNT, 1);
    check("impl_cnt", IMPL_CNT, 2);
`endif
    pop1();
    check("dup_pop_count", COUNT, 0);
    // Entry for var 5 survives its pop: same value is a duplicate
    push1(4'd5, 1'b0);
    check("kept_entry_dup", COUNT, 0);

    // Conflict, with a pop requested in the conflict cycle
    push1(4'd7, 1'b1);
    check("conf_pre_count", COUNT, 1);
    IMPL_READY = 1'b1;
    push1(4'd7, 1'b0);
    IMPL_READY = 1'b0;
    check("conf_flag",  CONFLICT, 1);
    check("conf_var",   CONFLICT_VAR, 7);
    check("conf_count", COUNT, 0);
    check("conf_ready", UNIT_READY, 0);
    check("conf_valid", IMPL_VALID, 0);
`ifdef BCP_IMPL_STATS_EN
    check("conf_cnt", CONF_CNT, 1);
`endif
    push1(4'd9, 1'b1);
    check("conf_blocked", COUNT, 0);
    check("conf_sticky",  CONFLICT, 1);
    do_clear();
    check("clr_flag",  CONFLICT, 0);
    check("clr_cvar",  CONFLICT_VAR, 0);
    check("clr_ready", UNIT_READY, 1);
    push1(4'd7, 1'b0);
    check("clr_table_empty", COUNT, 1);
    check("clr_table_val",   IMPL_VAL, 0);
    do_clear();
    check("clr_count", COUNT, 0);

    // Offset the pointers, then fill so the write pointer wraps
    push1(4'd10, 1'b1); push1(4'd11, 1'b1); push1(4'd12, 1'b1);
    pop1(); pop1(); pop1();
    check("offset_count", COUNT, 0);
    for (int i = 0; i < 8; i++) begin
      v = 4'(i);
      push1(v, v[0]);
    end
    check("full_count", COUNT, 8);
    check("full_ready", UNIT_READY, 0);
    // Full: no acceptance even with a pop in the same cycle
    IMPL_READY = 1'b1;
    push1(4'd13, 1'b1);
    IMPL_READY = 1'b0;
    check("full_no_bypass", COUNT, 7);
    check("full_head_after_pop", IMPL_VAR, 1);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("wrap_var%0d", i), IMPL_VAR, i);
      check($sformatf("wrap_val%0d", i), IMPL_VAL, i % 2);
      pop1();
    end
    check("drain_count", COUNT, 0);

    // Refill after CLEAR
    do_clear();
    for (int i = 8; i < 16; i++) begin
      v = 4'(i);
      push1(v, ~v[0]);
    end
    check("refill_count", COUNT, 8);
    for (int i = 8; i < 16; i++) begin
      check($sformatf("refill_var%0d", i), IMPL_VAR, i);
      check($sformatf("refill_val%0d", i), IMPL_VAL, (i + 1) % 2);
      pop1();
    end

    // Simultaneous push and pop at COUNT=3
    do_clear();
    push1(4'd1, 1'b1); push1(4'd2, 1'b1); push1(4'd3, 1'b1);
    check("sim_pre_count", COUNT, 3);
    IMPL_READY = 1'b1;
    push1(4'd4, 1'b0);
    IMPL_READY = 1'b0;
    check("sim_count", COUNT, 3);
    check("sim_head",  IMPL_VAR, 2);
    // Multi-bit flags: slot 3 (var 13, negated) beats slot 1 (var 14)
    push_raw(4'b1010, 16'hD0E0, 4'b0010);
    check("multi_count", COUNT, 4);
    pop1(); pop1();
    check("order_var4", IMPL_VAR, 4);
    check("order_val4", IMPL_VAL, 0);
    pop1();
    check("multi_var", IMPL_VAR, 13);
    check("multi_val", IMPL_VAL, 0);
    pop1();
    check("multi_drain", COUNT, 0);

    // Reset mid-operation
    do_clear();
    push1(4'd1, 1'b1); push1(4'd2, 1'b1); push1(4'd3, 1'b1); push1(4'd4, 1'b1);
    check("mid_pre_count", COUNT, 4);
    RST = 1'b1;
    tick();
    check("mid_rst_count", COUNT, 0);
    check("mid_rst_valid", IMPL_VALID, 0);
    check("mid_rst_var",   IMPL_VAR, 0);
    check("mid_rst_ready", UNIT_READY, 0);
    check("mid_rst_conf",  CONFLICT, 0);
`ifdef BCP_IMPL_STATS_EN
    check("mid_rst_impl_cnt", IMPL_CNT, 0);
`endif
    RST = 1'b0;
    tick();
    push1(4'd1, 1'b0);
    check("post_rst_conf",  CONFLICT, 0);
    check("post_rst_count", COUNT, 1);
    check("post_rst_head",  IMPL_VAR, 1);
    check("post_rst_hval",  IMPL_VAL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcp_implication_queue.md
Name: bcp_implication_queue

Overview:
- Consumer end of the BCP unit-clause check. It accepts one-hot unit-clause flags for a 4-literal clause, plus that clause's literal variable indices and polarities.
- It derives each implied variable assignment and records it in a pending-implication table.
- It detects conflicting implications and queues non-duplicate implications in a FIFO for the assignment writer.
- It sits between the unit-clause checker and the variable assignment memory.

Parameters:
- NUM_VARS, 16, number of solver variables tracked in the implication table.
- VAR_W, 4, variable index width; must satisfy 2**VAR_W >= NUM_VARS.
- DEPTH, 8, implication FIFO depth; must be a power of two, minimum 2.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- CLEAR  input  1  backtrack: wipe table, FIFO and conflict. Synchronous, one cycle.
- UNIT_VALID  input  1  unit-clause result valid.
- UNIT_READY  output  1  block can accept the unit result.
- UNIT_CLAUSE  input  4  unit flags, slot k set = literal k is the unit literal.
- CLAUSE_VARS  input  4*VAR_W  variable index of slot k at bits [k*VAR_W +: VAR_W].
- CLAUSE_POL  input  4  slot polarity, 1 = positive literal, 0 = negated.
- IMPL_VALID  output  1  FIFO head holds an implication.
- IMPL_READY  input  1  assignment writer accepts the head.
- IMPL_VAR  output  VAR_W  implied variable index.
- IMPL_VAL  output  1  implied variable value.
- CONFLICT  output  1  sticky conflict flag.
- CONFLICT_VAR  output  VAR_W  variable that caused the conflict.
- COUNT  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (RST=1): all outputs are 0; table is empty; FIFO is empty; state is RUN.
- RST takes priority over CLEAR, and CLEAR takes priority over all other inputs.
- States:
  - RUN: UNIT_READY = (COUNT != DEPTH).
  - CONFLICT: UNIT_READY = 0, IMPL_VALID = 0, CONFLICT = 1.
  - CONFLICT exits to RUN only through CLEAR or RST.
- Accept: UNIT_VALID & UNIT_READY in the same cycle. Inputs are sampled at that edge.
- Slot select: k = highest set bit of UNIT_CLAUSE. UNIT_CLAUSE = 0 is accepted as a no-op with no state change.
- Implied literal: var = CLAUSE_VARS slot k, val = CLAUSE_POL[k].
- Table lookup on accept, with three outcomes:
  - Var not present: set assigned[var] and value[var] = val, then push {var, val}.
  - Var present with the same value: duplicate. Drop it; no push.
  - Var present with the opposite value: enter CONFLICT next cycle and latch CONFLICT_VAR = var. The FIFO is flushed (COUNT becomes 0) and the table is left unchanged.
- Var >= NUM_VARS: treated as a no-op. The RTL carries a simulation-only assertion for this case.
- Latency: an accepted implication into an empty FIFO shows IMPL_VALID = 1 on the next cycle. There is no combinational bypass.
- Pop: IMPL_VALID & IMPL_READY advances the head. The table entry is kept after the pop; only CLEAR removes entries.
- Push and pop in the same cycle with a non-full FIFO: both occur and COUNT is unchanged.
- Full FIFO: UNIT_READY = 0, even if a pop happens in the same cycle (no full-bypass).
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- IMPL_VAR and IMPL_VAL hold the head entry while IMPL_VALID = 1. They are 0 when the FIFO is empty.
- Conflict cycle with a pop asserted: the flush wins and the pop is ignored.
- CLEAR: next cycle the table is empty, COUNT = 0, CONFLICT = 0, CONFLICT_VAR = 0 and state is RUN. Any accept or pop in the CLEAR cycle is discarded.

Optional Feature:
- Macro: BCP_IMPL_STATS_EN.
- When defined, three extra outputs are added, all reset to 0 by RST only (not by CLEAR):
  - IMPL_CNT (16 bits): counts pushes, saturating at 16'hFFFF.
  - DUP_CNT (16 bits): counts dropped duplicates, saturating.
  - CONF_CNT (8 bits): counts conflict entries, saturating.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Single push: after reset, UNIT_CLAUSE=4'b0100, slot2 var=5, CLAUSE_POL[2]=0 -> next cycle IMPL_VALID=1, IMPL_VAR=5, IMPL_VAL=0, COUNT=1. IMPL_READY=1 -> COUNT=0.
- Duplicate: push var3=1 twice with IMPL_READY=0 -> COUNT=1 and no second entry. With the macro, DUP_CNT=1.
- Conflict: push var7=1, then var7=0 -> CONFLICT=1, CONFLICT_VAR=7, COUNT=0, UNIT_READY=0. CLEAR -> CONFLICT=0 and UNIT_READY=1.
- Full and wrap: IMPL_READY=0, push 8 distinct vars -> COUNT=8 and UNIT_READY=0. Then drain and refill 8 more after CLEAR -> order is preserved across pointer wrap.
- Simultaneous events: with COUNT=3, push a new var while popping -> COUNT stays 3 and the head advances. Multi-bit UNIT_CLAUSE=4'b1010 -> slot 3 is selected.
- Reset mid-operation: RST with COUNT=4 and CONFLICT=0 -> all outputs 0. A previously implied var can be pushed again afterwards without conflict.
